// File: rtl/wb_arb_pkg.sv
// Shared definitions for the instruction/data Wishbone arbiter:
// arbiter state encoding and the bus-timeout counter width.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    localparam int TMO_CNT_W = 16;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus stall watchdog for the Wishbone arbiter. Counts stalled cycles while
// run=1 and emits a single-cycle expire pulse once the count reaches
// TIMEOUT_CYCLES. Built only when WB_ARB_TIMEOUT_EN is defined.
`ifdef WB_ARB_TIMEOUT_EN
module wb_arb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam logic [TMO_CNT_W-1:0] LIMIT = TMO_CNT_W'(TIMEOUT_CYCLES);

    logic [TMO_CNT_W-1:0] cnt_q;

    // The limit is compared against the registered count, so the pulse
    // comes one cycle after the last counted stall cycle.
    assign expire = (cnt_q == LIMIT);

    // Stall counter; clear wins, and the count holds at the limit.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (run && !expire) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/wb_imem_dmem_arbiter.sv
// Two-master Wishbone arbiter sharing one slave bus between the instruction
// master (m0) and the data master (m1). Round-robin on ties, grant held for
// as long as the owner keeps cyc asserted.
// Optional feature macro: WB_ARB_TIMEOUT_EN enables the stall watchdog that
// terminates a transfer with err after TIMEOUT_CYCLES unacknowledged cycles.
module wb_imem_dmem_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    // Master 0: instruction fetch
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic [DW-1:0]   m0_dat_o,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_stb_i,
    input  logic            m0_cyc_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    // Master 1: data access
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic [DW-1:0]   m1_dat_o,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_stb_i,
    input  logic            m1_cyc_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    // Shared slave bus
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_stb_o,
    output logic            s_cyc_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i
);

    // Out-of-range timeouts leave no legal elaboration target for the
    // 16-bit watchdog; this block only names the failing configuration.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout_cycles
    end

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_gnt_q;   // 0 = m0 granted last, 1 = m1 granted last
    logic       gnt0;
    logic       gnt1;
    logic       expire;

    assign gnt0 = (state_q == GNT0);
    assign gnt1 = (state_q == GNT1);

    // Next grant: tie broken against the last owner, handoff without idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_gnt_q ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i || expire) begin
                    state_d = m1_cyc_i ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i || expire) begin
                    state_d = m0_cyc_i ? GNT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant FSM and round-robin pointer; reset makes m0 win the first tie.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_d == GNT0 && state_q != GNT0) begin
                last_gnt_q <= 1'b0;
            end else if (state_d == GNT1 && state_q != GNT1) begin
                last_gnt_q <= 1'b1;
            end
        end
    end

    // Slave bus mux: owner's signals pass straight through, idle bus is all zero,
    // and an expiring transfer is dropped from the bus in the expire cycle.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        if (gnt0) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_stb_o = m0_stb_i;
            s_cyc_o = m0_cyc_i;
        end else if (gnt1) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_stb_o = m1_stb_i;
            s_cyc_o = m1_cyc_i;
        end
        if (expire) begin
            s_stb_o = 1'b0;
            s_cyc_o = 1'b0;
        end
    end

    // Acks go only to the owner and only while a strobe is on the bus;
    // read data is broadcast and qualified by ack.
    assign m0_ack_o = gnt0 & s_stb_o & s_ack_i;
    assign m1_ack_o = gnt1 & s_stb_o & s_ack_i;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
    logic stb_gnt;
    logic wd_run;
    logic wd_clear;

    // The owner's raw strobe is used so forcing s_stb_o low cannot feed back.
    assign stb_gnt  = (gnt0 & m0_stb_i) | (gnt1 & m1_stb_i);
    assign wd_run   = stb_gnt & ~s_ack_i;
    assign wd_clear = s_ack_i | ~stb_gnt | (state_d != state_q);

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .run      (wd_run),
        .clear    (wd_clear),
        .expire   (expire)
    );

    assign m0_err_o = gnt0 & expire;
    assign m1_err_o = gnt1 & expire;
`else
    assign expire   = 1'b0;
    assign m0_err_o = 1'b0;
    assign m1_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_imem_dmem_arbiter.sv
// Directed bench for wb_imem_dmem_arbiter. The timeout scenario checks the
// err pulse when WB_ARB_TIMEOUT_EN is defined, and the indefinite wait
// otherwise.
module tb_wb_imem_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i;
    logic [AW-1:0]   m0_adr_i, m1_adr_i;
    logic [DW-1:0]   m0_dat_i, m1_dat_i;
    logic [DW-1:0]   m0_dat_o, m1_dat_o;
    logic            m0_we_i, m1_we_i;
    logic [DW/8-1:0] m0_sel_i, m1_sel_i;
    logic            m0_stb_i, m1_stb_i;
    logic            m0_cyc_i, m1_cyc_i;
    logic            m0_ack_o, m1_ack_o;
    logic            m0_err_o, m1_err_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic            s_we_o;
    logic [DW/8-1:0] s_sel_o;
    logic            s_stb_o;
    logic            s_cyc_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i;

    logic            auto_ack;
    logic            s_ack_man;

    int compared   = 0;
    int mismatched = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    // Slave model: either manual ack or immediate ack of every strobe.
    assign s_ack_i = auto_ack ? s_stb_o : s_ack_man;

    wb_imem_dmem_arbiter #(
        .AW             (AW),
        .DW             (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .m0_adr_i (m0_adr_i),
        .m0_dat_i (m0_dat_i),
        .m0_dat_o (m0_dat_o),
        .m0_we_i  (m0_we_i),
        .m0_sel_i (m0_sel_i),
        .m0_stb_i (m0_stb_i),
        .m0_cyc_i (m0_cyc_i),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m1_adr_i (m1_adr_i),
        .m1_dat_i (m1_dat_i),
        .m1_dat_o (m1_dat_o),
        .m1_we_i  (m1_we_i),
        .m1_sel_i (m1_sel_i),
        .m1_stb_i (m1_stb_i),
        .m1_cyc_i (m1_cyc_i),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_we_o   (s_we_o),
        .s_sel_o  (s_sel_o),
        .s_stb_o  (s_stb_o),
        .s_cyc_o  (s_cyc_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    task automatic m0_req(input logic on, input logic [31:0] adr);
        m0_cyc_i = on;
        m0_stb_i = on;
        m0_adr_i = adr;
    endtask

    task automatic m1_req(input logic on, input logic [31:0] adr);
        m1_cyc_i = on;
        m1_stb_i = on;
        m1_adr_i = adr;
    endtask

    // Simulation time bound in case the stimulus sequence stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time bound");
        $fatal(1, "time bound expired");
    end

    initial begin
        int n_xfer;
        int n0, n1;
        logic p0, p1;
        logic [1:0] exp_who;

        wb_rst_i  = 1'b1;
        auto_ack  = 1'b0;
        s_ack_man = 1'b0;
        s_dat_i   = '0;
        m0_adr_i = '0; m0_dat_i = '0; m0_we_i = 1'b0; m0_sel_i = '0; m0_stb_i = 1'b0; m0_cyc_i = 1'b0;
        m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 1'b0; m1_sel_i = '0; m1_stb_i = 1'b0; m1_cyc_i = 1'b0;

        // Reset state: everything on the bus and to the masters is zero
        step(); settle();
        check("rst_s_cyc", s_cyc_o, 0);
        check("rst_s_stb", s_stb_o, 0);
        check("rst_s_adr", s_adr_o, 0);
        check("rst_m0_ack", m0_ack_o, 0);
        check("rst_m1_ack", m1_ack_o, 0);
        check("rst_m0_err", m0_err_o, 0);
        wb_rst_i = 1'b0;

        // Single master read by m1, ack on the second granted cycle
        step();
        m1_req(1'b1, 32'h0000_1000);
        m1_sel_i = 4'hF;
        settle();
        check("t1_idle_cyc", s_cyc_o, 0);
        step(); settle();
        check("t1_gnt_cyc", s_cyc_o, 1);
        check("t1_gnt_adr", s_adr_o, 32'h0000_1000);
        check("t1_gnt_we", s_we_o, 0);
        check("t1_noack_m1", m1_ack_o, 0);
        step();
        s_ack_man = 1'b1;
        s_dat_i   = 32'hDEAD_BEEF;
        settle();
        check("t1_ack_m1", m1_ack_o, 1);
        check("t1_dat_m1", m1_dat_o, 32'hDEAD_BEEF);
        check("t1_ack_m0", m0_ack_o, 0);
        step();
        s_ack_man = 1'b0;
        m1_req(1'b0, 32'h0);
        m1_sel_i = '0;
        step(); settle();
        check("t1_back_idle", s_cyc_o, 0);

        // Simultaneous request: m0 first, then m1 with no idle cycle
        m0_req(1'b1, 32'h0000_0100);
        m1_req(1'b1, 32'h0000_0200);
        step(); settle();
        check("t2_m0_first_adr", s_adr_o, 32'h0000_0100);
        check("t2_m0_first_cyc", s_cyc_o, 1);
        s_ack_man = 1'b1;
        settle();
        check("t2_m0_ack", m0_ack_o, 1);
        check("t2_m1_blocked", m1_ack_o, 0);
        step();
        s_ack_man = 1'b0;
        m0_req(1'b0, 32'h0);
        settle();
        check("t2_drop_cyc", s_cyc_o, 0);
        step(); settle();
        check("t2_m1_cyc", s_cyc_o, 1);
        check("t2_m1_adr", s_adr_o, 32'h0000_0200);
        m1_req(1'b0, 32'h0);
        step(); step();

        // Continuous requests with immediate slave ack: grants alternate
        m0_adr_i = 32'h0000_00A0;
        m1_adr_i = 32'h0000_00B0;
        auto_ack = 1'b1;
        p0 = 1'b0; p1 = 1'b0;
        n_xfer = 0; n0 = 0; n1 = 0;
        for (int c = 0; c < 24 && n_xfer < 8; c++) begin
            m0_cyc_i = !p0; m0_stb_i = !p0;
            m1_cyc_i = !p1; m1_stb_i = !p1;
            settle();
            if (m0_ack_o || m1_ack_o) begin
                exp_who = (n_xfer % 2 == 0) ? 2'b01 : 2'b10;
                check("t3_order", {m1_ack_o, m0_ack_o}, exp_who);
                check("t3_route_adr", s_adr_o, (n_xfer % 2 == 0) ? 32'h0000_00A0 : 32'h0000_00B0);
                if (m0_ack_o) n0++;
                if (m1_ack_o) n1++;
                n_xfer++;
            end
            p0 = m0_ack_o;
            p1 = m1_ack_o;
            step();
        end
        check("t3_xfers", n_xfer, 8);
        check("t3_m0_count", n0, 4);
        check("t3_m1_count", n1, 4);
        m0_req(1'b0, 32'h0);
        m1_req(1'b0, 32'h0);
        auto_ack = 1'b0;
        step(); step(); step();

        // m0 locks the bus for 3 beats while m1 waits
        m0_req(1'b1, 32'h0000_0300);
        step();
        m1_req(1'b1, 32'h0000_0400);
        for (int b = 0; b < 3; b++) begin
            m0_adr_i  = 32'h0000_0300 + 32'(4 * b);
            s_ack_man = 1'b1;
            s_dat_i   = 32'hC0DE_0000 + 32'(b);
            settle();
            check("t4_beat_m0_ack", m0_ack_o, 1);
            check("t4_beat_m1_ack", m1_ack_o, 0);
            check("t4_beat_adr", s_adr_o, 32'h0000_0300 + 32'(4 * b));
            check("t4_beat_dat", m0_dat_o, 32'hC0DE_0000 + 32'(b));
            step();
        end
        s_ack_man = 1'b0;
        m0_req(1'b0, 32'h0);
        settle();
        check("t4_release_cyc", s_cyc_o, 0);
        check("t4_release_m1_ack", m1_ack_o, 0);
        step();
        s_ack_man = 1'b1;
        settle();
        check("t4_m1_adr", s_adr_o, 32'h0000_0400);
        check("t4_m1_ack", m1_ack_o, 1);
        step();
        s_ack_man = 1'b0;
        m1_req(1'b0, 32'h0);
        step(); step();

        // Reset asserted in the middle of an m1 write
        m1_req(1'b1, 32'h0000_2000);
        m1_we_i  = 1'b1;
        m1_dat_i = 32'h1234_5678;
        m1_sel_i = 4'hF;
        step(); settle();
        check("t5_wr_cyc", s_cyc_o, 1);
        check("t5_wr_we", s_we_o, 1);
        check("t5_wr_dat", s_dat_o, 32'h1234_5678);
        check("t5_wr_sel", s_sel_o, 4'hF);
        s_ack_man = 1'b1;
        wb_rst_i  = 1'b1;
        settle();
        check("t5_rst_cyc", s_cyc_o, 0);
        check("t5_rst_stb", s_stb_o, 0);
        check("t5_rst_m1_ack", m1_ack_o, 0);
        m0_req(1'b1, 32'h0000_3000);
        step();
        wb_rst_i = 1'b0;
        step(); settle();
        check("t5_tie_adr", s_adr_o, 32'h0000_3000);
        check("t5_tie_m0_ack", m0_ack_o, 1);
        check("t5_tie_m1_ack", m1_ack_o, 0);
        s_ack_man = 1'b0;
        m0_req(1'b0, 32'h0);
        step(); settle();
        check("t5_handoff_adr", s_adr_o, 32'h0000_2000);
        m1_req(1'b0, 32'h0);
        m1_we_i = 1'b0;
        m1_sel_i = '0;
        step(); step();

        // Reset restores the round-robin pointer after m0 was last served
        m0_req(1'b1, 32'h0000_3100);
        step(); step();
        m0_req(1'b0, 32'h0);
        step(); step();
        wb_rst_i = 1'b1;
        step();
        wb_rst_i = 1'b0;
        m0_req(1'b1, 32'h0000_3200);
        m1_req(1'b1, 32'h0000_3300);
        step(); settle();
        check("t6_tie_after_rst", s_adr_o, 32'h0000_3200);
        m0_req(1'b0, 32'h0);
        m1_req(1'b0, 32'h0);
        step(); step(); step();

        // Slave never acks while m1 waits
        m0_req(1'b1, 32'h0000_0500);
        step();
        m1_req(1'b1, 32'h0000_0600);
        for (int s = 0; s < 4; s++) begin
            settle();
            check("t7_stall_cyc", s_cyc_o, 1);
            check("t7_stall_err", m0_err_o, 0);
            step();
        end
        settle();
`ifdef WB_ARB_TIMEOUT_EN
        check("t7_err_m0", m0_err_o, 1);
        check("t7_err_m1", m1_err_o, 0);
        check("t7_err_cyc", s_cyc_o, 0);
        check("t7_err_stb", s_stb_o, 0);
        step(); settle();
        check("t7_next_m1_adr", s_adr_o, 32'h0000_0600);
        check("t7_next_m1_cyc", s_cyc_o, 1);
        check("t7_next_err", m0_err_o, 0);
`else
        check("t7_noerr_m0", m0_err_o, 0);
        check("t7_hold_cyc", s_cyc_o, 1);
        step(); settle();
        check("t7_hold_adr", s_adr_o, 32'h0000_0500);
        check("t7_noerr_m1", m1_err_o, 0);
`endif
        m0_req(1'b0, 32'h0);
        m1_req(1'b0, 32'h0);
        step(); step(); step(); settle();
        check("end_idle_cyc", s_cyc_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
